// File: rtl/vga_dbuf_scaler.sv
// vga_dbuf_scaler: two-bank virtual-resolution framebuffer with integer up-scaling.
// The drawer writes or bulk-clears the back bank; the front bank is scanned out with a fixed
// 3-cycle latency. Bank swaps commit only on the rising edge of frame_done (vertical blanking).
module vga_dbuf_scaler #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned SCALE_LOG2 = 2,
   parameter int unsigned COLOR_W    = 24,
   localparam int unsigned VW        = H_ACTIVE >> SCALE_LOG2,
   localparam int unsigned VH        = V_ACTIVE >> SCALE_LOG2,
   localparam int unsigned DEPTH     = VW * VH,
   localparam int unsigned AW        = $clog2(DEPTH),
   localparam int unsigned XW        = $clog2(VW),
   localparam int unsigned YW        = $clog2(VH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   input  logic               active_pixels,
   input  logic               frame_done,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [XW-1:0]      wr_x,
   input  logic [YW-1:0]      wr_y,
   input  logic [COLOR_W-1:0] wr_data,
   output logic               wr_oob,
   input  logic               clr_req,
   input  logic [COLOR_W-1:0] clr_color,
   output logic               clr_busy,
   input  logic               swap_req,
   output logic               swap_pending,
   output logic               swap_done,
   output logic               front_id,
   output logic [COLOR_W-1:0] pix_out,
   output logic               pix_valid
);

   localparam logic [AW-1:0] VW_A     = AW'(VW);
   localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StClear, StSwapWait} state_e;

   state_e               state_q;
   logic                 front_q;
   logic                 swap_latch_q;
   logic [AW-1:0]        clr_cnt_q;
   logic [COLOR_W-1:0]   clr_color_q;
   logic                 swap_done_q;
   logic                 wr_oob_q;
   logic                 fd_prev_q;

   logic                 wr_in_range;
   logic [AW-1:0]        wr_addr;

   logic                 ram_we;
   logic [AW-1:0]        ram_waddr;
   logic [COLOR_W-1:0]   ram_wdata;

   logic [COLOR_W-1:0]   mem0 [DEPTH];
   logic [COLOR_W-1:0]   mem1 [DEPTH];

   logic [9:0]           scan_vx;
   logic [9:0]           scan_vy;
   logic [AW-1:0]        scan_addr;
   logic                 scan_act;

   logic [AW-1:0]        s1_addr_q;
   logic                 s1_bank_q;
   logic                 s1_act_q;
   logic [COLOR_W-1:0]   rd0_q;
   logic [COLOR_W-1:0]   rd1_q;
   logic                 s2_bank_q;
   logic                 s2_act_q;

   // Drawer-side address and range check; zero-extended compares stay correct for any VW/VH.
   assign wr_in_range = (32'(wr_x) < VW) && (32'(wr_y) < VH);
   assign wr_addr     = AW'(wr_y) * VW_A + AW'(wr_x);

   // Requests in the same cycle always beat a pixel write.
   assign wr_ready     = (state_q == StIdle) && !clr_req && !swap_req;
   assign clr_busy     = (state_q == StClear);
   assign swap_pending = (state_q == StSwapWait) || swap_latch_q;
   assign swap_done    = swap_done_q;
   assign wr_oob       = wr_oob_q;
   assign front_id     = front_q;

   // Control FSM: idle/write acceptance, sequential bank clear, and frame-aligned swap commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         front_q      <= 1'b0;
         swap_latch_q <= 1'b0;
         clr_cnt_q    <= '0;
         clr_color_q  <= '0;
         swap_done_q  <= 1'b0;
         wr_oob_q     <= 1'b0;
         fd_prev_q    <= frame_done;
      end else begin
         swap_done_q <= 1'b0;
         wr_oob_q    <= 1'b0;
         fd_prev_q   <= frame_done;
         unique case (state_q)
            StIdle: begin
               if (clr_req) begin
                  clr_color_q  <= clr_color;
                  clr_cnt_q    <= '0;
                  swap_latch_q <= swap_req;
                  state_q      <= StClear;
               end else if (swap_req) begin
                  state_q <= StSwapWait;
               end else if (wr_valid && !wr_in_range) begin
                  wr_oob_q <= 1'b1;
               end
            end
            StClear: begin
               if (swap_req) begin
                  swap_latch_q <= 1'b1;
               end
               if (clr_cnt_q == CLR_LAST) begin
                  // A swap arriving on the final clear cycle must not be lost.
                  state_q <= (swap_latch_q || swap_req) ? StSwapWait : StIdle;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            StSwapWait: begin
               // Edge detect: a level already high on entry does not commit.
               if (frame_done && !fd_prev_q) begin
                  front_q      <= ~front_q;
                  swap_done_q  <= 1'b1;
                  swap_latch_q <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Back-bank write port: the clear sweep owns it while busy, otherwise accepted in-range writes.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
      if (!rst) begin
         if (state_q == StClear) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = clr_color_q;
         end else if (wr_ready && wr_valid && wr_in_range) begin
            ram_we = 1'b1;
         end
      end
   end

   // Bank 0: written only while it is the back bank; synchronous read for scan-out.
   always_ff @(posedge clk) begin
      if (ram_we && front_q) begin
         mem0[ram_waddr] <= ram_wdata;
      end
      rd0_q <= mem0[s1_addr_q];
   end

   // Bank 1: written only while it is the back bank; synchronous read for scan-out.
   always_ff @(posedge clk) begin
      if (ram_we && !front_q) begin
         mem1[ram_waddr] <= ram_wdata;
      end
      rd1_q <= mem1[s1_addr_q];
   end

   // Scan position to virtual address; vy*VW is a constant multiply, vx is added directly.
   assign scan_vx   = x >> SCALE_LOG2;
   assign scan_vy   = y >> SCALE_LOG2;
   assign scan_addr = AW'(scan_vy) * VW_A + AW'(scan_vx);
   assign scan_act  = active_pixels && (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);

   // Readout pipeline: S1 address/bank/active, S2 RAM read, S3 registered pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_addr_q <= '0;
         s1_bank_q <= 1'b0;
         s1_act_q  <= 1'b0;
         s2_bank_q <= 1'b0;
         s2_act_q  <= 1'b0;
         pix_out   <= '0;
         pix_valid <= 1'b0;
      end else begin
         s1_addr_q <= scan_addr;
         s1_bank_q <= front_q;
         s1_act_q  <= scan_act;
         s2_bank_q <= s1_bank_q;
         s2_act_q  <= s1_act_q;
         pix_valid <= s2_act_q;
         if (s2_act_q) begin
            pix_out <= s2_bank_q ? rd1_q : rd0_q;
         end else begin
            pix_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_dbuf_scaler.sv
// Self-checking bench for vga_dbuf_scaler: frame-level behavioural model plus directed literals.
module tb_vga_dbuf_scaler;

   localparam int HA    = 640;
   localparam int VA    = 480;
   localparam int VW    = 160;
   localparam int VH    = 120;
   localparam int DEPTH = VW * VH;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic        active_pixels = 1'b0;
   logic        frame_done = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [7:0]  wr_x = '0;
   logic [6:0]  wr_y = '0;
   logic [23:0] wr_data = '0;
   logic        wr_oob;
   logic        clr_req = 1'b0;
   logic [23:0] clr_color = '0;
   logic        clr_busy;
   logic        swap_req = 1'b0;
   logic        swap_pending;
   logic        swap_done;
   logic        front_id;
   logic [23:0] pix_out;
   logic        pix_valid;

   vga_dbuf_scaler #(
      .H_ACTIVE  (HA),
      .V_ACTIVE  (VA),
      .SCALE_LOG2(2),
      .COLOR_W   (24)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .x            (x),
      .y            (y),
      .active_pixels(active_pixels),
      .frame_done   (frame_done),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_x         (wr_x),
      .wr_y         (wr_y),
      .wr_data      (wr_data),
      .wr_oob       (wr_oob),
      .clr_req      (clr_req),
      .clr_color    (clr_color),
      .clr_busy     (clr_busy),
      .swap_req     (swap_req),
      .swap_pending (swap_pending),
      .swap_done    (swap_done),
      .front_id     (front_id),
      .pix_out      (pix_out),
      .pix_valid    (pix_valid)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   logic [23:0] mmem   [2][DEPTH];
   bit          mknown [2][DEPTH];
   int          busy_left = 0;
   logic [23:0] m_col = '0;
   bit          armed = 1'b0;
   bit          m_fd_prev = 1'b0;
   bit          m_front = 1'b0;
   bit          done_p = 1'b0;
   bit          oob_p = 1'b0;
   bit          pv [3] = '{0, 0, 0};
   logic [23:0] pd [3] = '{0, 0, 0};
   bit          pk [3] = '{1, 1, 1};

   // Model advances once per clock using the inputs presented during that cycle.
   initial forever begin
      int          xi, yi, a, back;
      bit          ev, ek;
      logic [23:0] ed;
      @(posedge clk);
      if (rst) begin
         busy_left = 0;
         armed     = 1'b0;
         m_front   = 1'b0;
         done_p    = 1'b0;
         oob_p     = 1'b0;
         m_fd_prev = frame_done;
         for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
            pk[i] = 1'b1;
         end
      end else begin
         xi = int'(x);
         yi = int'(y);
         ev = active_pixels && xi < HA && yi < VA;
         ed = '0;
         ek = 1'b1;
         if (ev) begin
            a  = (yi / 4) * VW + xi / 4;
            ed = mmem[m_front ? 1 : 0][a];
            ek = mknown[m_front ? 1 : 0][a];
         end
         pv[2] = pv[1]; pd[2] = pd[1]; pk[2] = pk[1];
         pv[1] = pv[0]; pd[1] = pd[0]; pk[1] = pk[0];
         pv[0] = ev;    pd[0] = ed;    pk[0] = ek;
         back   = m_front ? 0 : 1;
         done_p = 1'b0;
         oob_p  = 1'b0;
         if (busy_left > 0) begin
            mmem[back][DEPTH - busy_left]   = m_col;
            mknown[back][DEPTH - busy_left] = 1'b1;
            busy_left--;
            if (swap_req) armed = 1'b1;
         end else if (armed) begin
            if (frame_done && !m_fd_prev) begin
               m_front = !m_front;
               done_p  = 1'b1;
               armed   = 1'b0;
            end
         end else if (clr_req) begin
            busy_left = DEPTH;
            m_col     = clr_color;
            armed     = swap_req;
         end else if (swap_req) begin
            armed = 1'b1;
         end else if (wr_valid) begin
            if (int'(wr_x) < VW && int'(wr_y) < VH) begin
               mmem[back][int'(wr_y) * VW + int'(wr_x)]   = wr_data;
               mknown[back][int'(wr_y) * VW + int'(wr_x)] = 1'b1;
            end else begin
               oob_p = 1'b1;
            end
         end
         m_fd_prev = frame_done;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("m_wr_ready", wr_ready, (busy_left == 0 && !armed && !clr_req && !swap_req));
         chk("m_clr_busy", clr_busy, busy_left > 0);
         chk("m_swap_pending", swap_pending, armed);
         chk("m_swap_done", swap_done, done_p);
         chk("m_front_id", front_id, m_front);
         chk("m_wr_oob", wr_oob, oob_p);
         chk("m_pix_valid", pix_valid, pv[2]);
         if (pk[2]) chk("m_pix_out", pix_out, pd[2]);
      end
   end

   initial begin
      #1500000;
      $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1, "timeout");
   end

   // Issue one scan position, then check the pixel three cycles later.
   task automatic scan_one(input int sx, input int sy, input bit act, input bit ev,
                           input logic [23:0] ed, input string nm);
      x = 10'(sx);
      y = 10'(sy);
      active_pixels = act;
      step();
      active_pixels = 1'b0;
      step();
      step();
      @(negedge clk);
      chk({nm, "_valid"}, pix_valid, ev);
      chk({nm, "_data"}, pix_out, ed);
      step();
   endtask

   initial begin
      int busy_cnt, rdy_bad, early, dn;

      // Reset
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_swap_pending", swap_pending, 0);
      chk("rst_swap_done", swap_done, 0);
      chk("rst_wr_oob", wr_oob, 0);
      chk("rst_front_id", front_id, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_out", pix_out, 0);

      // Writes into bank 1 (back), plus an out-of-range write aliasing onto (0,2)
      step(); wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd2; wr_data = 24'hFF0000;
      step(); wr_x = 8'd4; wr_data = 24'h0000FF;
      step(); wr_x = 8'd0; wr_data = 24'h0000AA;
      step(); wr_x = 8'd160; wr_y = 7'd1; wr_data = 24'h123456;
      step(); wr_valid = 1'b0;
      @(negedge clk);
      chk("oob_pulse", wr_oob, 1);
      step();
      @(negedge clk);
      chk("oob_single", wr_oob, 0);

      // Swap commit on frame_done rising edge
      step(); swap_req = 1'b1;
      step(); swap_req = 1'b0;
      @(negedge clk);
      chk("t1_pending", swap_pending, 1);
      chk("t1_ready_blocked", wr_ready, 0);
      step(); step(); step();
      frame_done = 1'b1;
      step();
      @(negedge clk);
      chk("t1_swap_done", swap_done, 1);
      chk("t1_front", front_id, 1);
      step();
      @(negedge clk);
      chk("t1_swap_done_once", swap_done, 0);
      step();
      frame_done = 1'b0;

      for (int yy = 8; yy < 12; yy++)
         for (int xx = 12; xx < 16; xx++)
            scan_one(xx, yy, 1'b1, 1'b1, 24'hFF0000, "t1_red");
      scan_one(16, 8, 1'b1, 1'b1, 24'h0000FF, "t1_neighbour");
      scan_one(1, 10, 1'b1, 1'b1, 24'h0000AA, "t4_oob_untouched");

      // Clear with a simultaneous write, swap latched mid-clear, frame_done high at clear end
      clr_req = 1'b1; clr_color = 24'h00FF00;
      wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd5; wr_data = 24'hABCDEF;
      @(negedge clk);
      chk("t4_clr_beats_write", wr_ready, 0);
      busy_cnt = 0;
      rdy_bad  = 0;
      for (int i = 0; i < 25000; i++) begin
         step();
         clr_req  = 1'b0;
         swap_req = (i == 100);
         if (i == 19000) frame_done = 1'b1;
         @(negedge clk);
         if (clr_busy) busy_cnt++;
         if (clr_busy && wr_ready) rdy_bad++;
         if (!clr_busy) break;
      end
      wr_valid = 1'b0;
      chk("t2_busy_cycles", busy_cnt, DEPTH);
      chk("t2_ready_low", rdy_bad, 0);
      chk("t3_pending_after_clear", swap_pending, 1);
      early = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         if (swap_done) early++;
      end
      chk("t3_no_commit_on_level", early, 0);
      chk("t3_front_held", front_id, 1);
      step(); frame_done = 1'b0;
      step(); step(); step();
      frame_done = 1'b1;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         if (swap_done) dn++;
      end
      chk("t3_one_swap_done", dn, 1);
      chk("t3_front_after", front_id, 0);
      chk("t3_pending_clear", swap_pending, 0);
      step(); frame_done = 1'b0;

      // Cleared bank now displayed
      scan_one(100, 200, 1'b1, 1'b1, 24'h00FF00, "t2_green");
      scan_one(639, 479, 1'b1, 1'b1, 24'h00FF00, "t2_green_corner");
      for (int i = 0; i < 300; i++) begin
         active_pixels = 1'b1;
         x = 10'($urandom_range(0, HA - 1));
         y = 10'($urandom_range(0, VA - 1));
         step();
      end
      active_pixels = 1'b0;
      step(); step(); step();

      // Inactive and out-of-range scans
      scan_one(20, 20, 1'b0, 1'b0, 24'h0, "t5_inactive");
      scan_one(700, 20, 1'b1, 1'b0, 24'h0, "t5_x700");
      scan_one(20, 480, 1'b1, 1'b0, 24'h0, "t5_y480");

      // Randomised frames: scan window then blanking with a frame_done pulse
      for (int f = 0; f < 20; f++) begin
         for (int c = 0; c < 60; c++) begin
            active_pixels = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                            : 10'($urandom_range(0, 39));
            y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                            : 10'($urandom_range(0, 39));
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(150, 255))
                                               : 8'($urandom_range(0, 9));
            wr_y = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(110, 127))
                                               : 7'($urandom_range(0, 9));
            wr_data  = 24'($urandom);
            swap_req = ($urandom_range(0, 29) == 0);
            step();
         end
         swap_req = 1'b0;
         active_pixels = 1'b0;
         wr_valid = 1'b0;
         repeat (4) step();
         frame_done = 1'b1;
         repeat (4) step();
         frame_done = 1'b0;
         repeat (4) step();
      end

      // Make bank 1 the front so the reset check on front_id is meaningful
      if (!front_id) begin
         swap_req = 1'b1;
         step();
         swap_req = 1'b0;
         step();
         frame_done = 1'b1;
         step();
         frame_done = 1'b0;
         step();
      end

      // Reset in the middle of a clear (count 5000)
      clr_req = 1'b1; clr_color = 24'h0000FF;
      step();
      clr_req = 1'b0;
      repeat (5000) step();
      @(negedge clk);
      chk("t6_busy_before", clr_busy, 1);
      chk("t6_front_before", front_id, 1);
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("t6_clr_busy", clr_busy, 0);
      chk("t6_swap_pending", swap_pending, 0);
      chk("t6_swap_done", swap_done, 0);
      chk("t6_wr_oob", wr_oob, 0);
      chk("t6_front_id", front_id, 0);
      chk("t6_pix_valid", pix_valid, 0);
      chk("t6_pix_out", pix_out, 0);
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      chk("t6_idle_ready", wr_ready, 1);
      chk("t6_still_idle", clr_busy, 0);
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_dbuf_scaler.md
# vga_dbuf_scaler

Parametrised double-buffered framebuffer with integer up-scaling, placed between the drawing logic and `vga_driver`. It holds two internal virtual-resolution banks. Drawing logic writes pixels, or bulk-clears, into the back bank through a valid/ready port. The front bank is scanned out at fixed latency from the driver's x/y. Bank swap is requested by the drawer and committed only at the frame boundary, so the display never tears.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `SCALE_LOG2`, 2, each virtual pixel is 2^SCALE_LOG2 screen pixels square
- `COLOR_W`, 24, pixel width ({R,G,B})
- Derived (localparam):
  - VW = H_ACTIVE>>SCALE_LOG2
  - VH = V_ACTIVE>>SCALE_LOG2
  - DEPTH = VW*VH
  - AW = clog2(DEPTH)
  - XW = clog2(VW)
  - YW = clog2(VH)

Clock and reset: one clock; reset is synchronous and active-high.

- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `x`, `y` in 10 each: scan position from `vga_driver`
- `active_pixels` in 1: scan position is inside the active area
- `frame_done` in 1: high during vertical blanking
- `wr_valid` in 1: write request
- `wr_ready` out 1: write accepted this cycle when `wr_valid` && `wr_ready`
- `wr_x` in XW: virtual x of the write
- `wr_y` in YW: virtual y of the write
- `wr_data` in COLOR_W: write pixel
- `wr_oob` out 1: one-cycle pulse when an accepted write is out of range and dropped
- `clr_req` in 1: pulse, fill the back bank with `clr_color`
- `clr_color` in COLOR_W: sampled in the cycle `clr_req` is taken
- `clr_busy` out 1: clear in progress
- `swap_req` in 1: pulse, request a front/back exchange
- `swap_pending` out 1: a swap is latched and not yet committed
- `swap_done` out 1: one-cycle pulse on commit
- `front_id` out 1: bank currently displayed
- `pix_out` out COLOR_W: display pixel
- `pix_valid` out 1: `pix_out` is an active pixel

## Operation

Banks and storage:
- Two banks, each DEPTH x COLOR_W, inferred synchronous-read RAM.
- Back bank = !front_id. Writes and clears only ever touch the back bank.
- Address is row-major: addr = vy*VW + vx.

Control FSM states: IDLE, CLEAR, SWAP_WAIT.

IDLE:
- `wr_ready` = (state==IDLE) && !clr_req && !swap_req. This is combinational; a clear or swap request always wins over a write in the same cycle.
- An accepted write with wr_x<VW and wr_y<VH writes the back bank.
- An accepted write that is out of range is dropped and pulses `wr_oob` the next cycle.
- `clr_req`: latch `clr_color`, set clear counter to 0, go to CLEAR.
- `swap_req` without `clr_req`: go to SWAP_WAIT.

CLEAR:
- Writes `clr_color` at counter address, one address per cycle, for DEPTH cycles.
- `clr_busy`=1 for exactly DEPTH cycles.
- After writing address DEPTH-1: go to SWAP_WAIT if a swap was latched during the clear, else go to IDLE.
- `clr_req` in this state is ignored. `swap_req` in this state sets the swap latch.
- `clr_req` and `swap_req` in the same IDLE cycle: clear first, then the swap is latched.

SWAP_WAIT:
- Waits for a rising edge of `frame_done`; the previous value of `frame_done` is held in a register.
- On that edge: toggle `front_id`, pulse `swap_done` for one cycle, clear the latch, go to IDLE.
- If `frame_done` is already high on entry, the block waits for the next rising edge.
- `swap_pending` = (state==SWAP_WAIT) || latch.
- Repeated `swap_req` while pending has no effect; a swap is never counted twice.

Readout:
- vx = x>>SCALE_LOG2, vy = y>>SCALE_LOG2.
- vx*VW is never used. vy*VW is formed as a constant multiply of width AW.
- If `active_pixels` is low or x>=H_ACTIVE or y>=V_ACTIVE: `pix_valid`=0 and `pix_out`=0.

Reset:
- state=IDLE, front_id=0, latch=0.
- Outputs: clr_busy=0, swap_pending=0, swap_done=0, wr_oob=0, pix_valid=0, pix_out=0.
- `wr_ready` is 1 after reset once requests are low.
- RAM contents are not reset.
- Reset during CLEAR aborts it; the bank is then partially cleared, which is legal.

## Timing
- Readout pipeline, 3 cycles:
  - S1 registers address, front-bank select and active.
  - S2 is the RAM read.
  - S3 registers `pix_out`/`pix_valid`.
- An input x/y/active_pixels at cycle n appears at `pix_out` at n+3.
- The front select is sampled in S1. A swap committed at cycle n affects pixels whose x/y were sampled at n+1 or later. Because commits occur only at the `frame_done` edge, this is always inside blanking.
- A write accepted at cycle n is readable from the back bank at n+1.
- Clear started at cycle n (the `clr_req` cycle):
  - `clr_busy` is high from n+1 through n+DEPTH.
  - `wr_ready` returns at n+DEPTH+1 if no swap is latched.
- `swap_done` is asserted the cycle after the `frame_done` rising edge is seen. `front_id` changes in that same cycle.

## Test plan
1. Reset, write (3,2)=0xFF0000 into bank 1, `swap_req`, pulse `frame_done` -> `swap_done` once, `front_id`=1; scan x=12..15, y=8..11 -> `pix_out`=0xFF0000 with `pix_valid`=1, 3 cycles after each input; the neighbouring virtual pixel (4,2) is unaffected.
2. `clr_req` with `clr_color`=0x00FF00 -> `clr_busy` high for exactly 19200 cycles and `wr_ready`=0 throughout; after swap, every active pixel reads 0x00FF00.
3. `swap_req` during CLEAR, with `frame_done` already high when the clear ends -> no commit until the next low-to-high edge of `frame_done`; one `swap_done`.
4. Write with wr_x=160 -> accepted, `wr_oob` pulses, RAM unchanged. `wr_valid` in the same cycle as `clr_req` -> `wr_ready`=0 and the write is not taken.
5. Scan with `active_pixels`=0, and scan with x=700 -> `pix_valid`=0 and `pix_out`=0 at +3.
6. Assert `rst` mid-clear at count 5000 -> all outputs at reset values the next cycle; state IDLE; `front_id`=0.
